// File: rtl/adder_sum_accumulator.sv
// Batch accumulator for the results of an upstream registered adder.
// Sums are added into a wide accumulator until BATCH_LEN items have been
// taken or a flush closes a partial batch; the batch total, item count and a
// sticky wrap flag are then held on the output until the consumer takes them.
module adder_sum_accumulator #(
    parameter int ADDER_WIDTH = 114,
    parameter int ACC_WIDTH   = 128,
    parameter int BATCH_LEN   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [ADDER_WIDTH:0]   in_sum,
    output logic                   in_ready,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_WIDTH-1:0]   out_total,
    output logic [15:0]            out_count,
    output logic                   out_overflow
);

    localparam logic [15:0] BATCH_LEN_C = 16'(BATCH_LEN);

    // Reject parameter sets that would truncate an incoming sum or the count.
    if (ACC_WIDTH < ADDER_WIDTH + 1) begin : g_bad_acc_width
        $error("adder_sum_accumulator: ACC_WIDTH must be >= ADDER_WIDTH+1");
    end
    if (BATCH_LEN < 1 || BATCH_LEN > 65535) begin : g_bad_batch_len
        $error("adder_sum_accumulator: BATCH_LEN must be in 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    logic [ACC_WIDTH-1:0]   r_acc;
    logic [15:0]            r_count;
    logic                   r_ovf;

    logic                   r_in_ready;
    logic                   r_out_valid;
    logic [ACC_WIDTH-1:0]   r_out_total;
    logic [15:0]            r_out_count;
    logic                   r_out_ovf;

    logic                   w_accept;
    logic                   w_handoff;
    logic                   w_close;
    logic [ACC_WIDTH:0]     w_add;
    logic [ACC_WIDTH-1:0]   w_acc_new;
    logic [15:0]            w_count_inc;
    logic [15:0]            w_count_new;
    logic                   w_ovf_new;

    // r_in_ready is only ever 1 in ACCUM, so it alone qualifies an accept.
    assign w_accept    = in_valid && r_in_ready;
    assign w_handoff   = r_out_valid && out_ready;

    // One extra bit on the adder captures the carry out of the accumulator.
    assign w_add       = {1'b0, r_acc} + {{(ACC_WIDTH - ADDER_WIDTH){1'b0}}, in_sum};
    assign w_count_inc = r_count + 16'd1;

    // Accumulator state after this cycle's accept, if any.
    assign w_acc_new   = w_accept ? w_add[ACC_WIDTH-1:0] : r_acc;
    assign w_count_new = w_accept ? w_count_inc : r_count;
    assign w_ovf_new   = r_ovf | (w_accept & w_add[ACC_WIDTH]);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of block ordering.
            r_state <= w_next_state;
        end
    end

    // Next-state logic and batch-close decision.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_next_state = r_state;
        w_close      = 1'b0;
        case (r_state)
            IDLE: begin
                w_next_state = ACCUM;
            end
            ACCUM: begin
                // A flush closes the batch only if it would not be empty; an
                // item accepted alongside the flush belongs to this batch.
                w_close = (w_accept && (w_count_inc == BATCH_LEN_C))
                       || (flush && ((r_count != 16'd0) || w_accept));
                if (w_close) begin
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                if (w_handoff) begin
                    w_next_state = ACCUM;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Accumulator, sticky overflow and registered output interface.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_total <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            r_in_ready <= (w_next_state == ACCUM);
            if (w_handoff) begin
                // Result taken: start a fresh batch. in_ready rises on this
                // same edge, so the next sum is taken on the following one.
                r_acc       <= '0;
                r_count     <= '0;
                r_ovf       <= 1'b0;
                r_out_valid <= 1'b0;
            end else begin
                r_acc   <= w_acc_new;
                r_count <= w_count_new;
                r_ovf   <= w_ovf_new;
                if (w_close) begin
                    r_out_valid <= 1'b1;
                    r_out_total <= w_acc_new;
                    r_out_count <= w_count_new;
                    r_out_ovf   <= w_ovf_new;
                end
            end
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_total    = r_out_total;
    assign out_count    = r_out_count;
    assign out_overflow = r_out_ovf;

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Directed bench for adder_sum_accumulator with ADDER_WIDTH=114,
// ACC_WIDTH=116, BATCH_LEN=4. Inputs change 1 ns after a rising edge and
// outputs are sampled at the same point, well away from the next edge.
module tb_adder_sum_accumulator;

    localparam int ADDER_WIDTH = 114;
    localparam int ACC_WIDTH   = 116;
    localparam int BATCH_LEN   = 4;

    logic                   clk;
    logic                   rst_n;
    logic                   in_valid;
    logic [ADDER_WIDTH:0]   in_sum;
    logic                   in_ready;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    logic [ACC_WIDTH-1:0]   out_total;
    logic [15:0]            out_count;
    logic                   out_overflow;

    int checks   = 0;
    int failures = 0;

    adder_sum_accumulator #(
        .ADDER_WIDTH (ADDER_WIDTH),
        .ACC_WIDTH   (ACC_WIDTH),
        .BATCH_LEN   (BATCH_LEN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_sum       (in_sum),
        .in_ready     (in_ready),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_total    (out_total),
        .out_count    (out_count),
        .out_overflow (out_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [ADDER_WIDTH:0] s, input logic f);
        in_valid = v;
        in_sum   = s;
        flush    = f;
    endtask

    logic [ADDER_WIDTH:0]  max_sum;
    logic [ACC_WIDTH-1:0]  wrap_total;

    initial begin
        max_sum    = {(ADDER_WIDTH + 1){1'b1}};
        wrap_total = {ACC_WIDTH{1'b1}} - 116'd3;   // 2^116 - 4

        rst_n     = 1'b0;
        out_ready = 1'b0;
        put(1'b0, '0, 1'b0);
        #23;
        check("rst_in_ready",  in_ready,     0);
        check("rst_out_valid", out_valid,    0);
        check("rst_out_total", out_total,    0);
        check("rst_out_count", out_count,    0);
        check("rst_out_ovf",   out_overflow, 0);

        // Release between edges; the first edge moves IDLE -> ACCUM.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_in_ready", in_ready, 0);
        tick();
        check("accum_in_ready", in_ready, 1);

        // Full batch 1,2,3,4 with the consumer ready.
        out_ready = 1'b1;
        put(1'b1, 1, 1'b0); tick();
        check("mid_batch_no_valid", out_valid, 0);
        put(1'b1, 2, 1'b0); tick();
        put(1'b1, 3, 1'b0); tick();
        put(1'b1, 4, 1'b0); tick();
        put(1'b0, 0, 1'b0);
        check("b1_valid",    out_valid,    1);
        check("b1_total",    out_total,    10);
        check("b1_count",    out_count,    4);
        check("b1_ovf",      out_overflow, 0);
        check("b1_in_ready", in_ready,     0);
        tick();
        check("b1_handoff_valid", out_valid, 0);
        check("b1_in_ready_back", in_ready,  1);

        // Four maximal sums wrap a 116-bit accumulator; consumer stalls.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put(1'b1, max_sum, 1'b0);
            tick();
        end
        check("b2_valid", out_valid,    1);
        check("b2_total", out_total,    wrap_total);
        check("b2_count", out_count,    4);
        check("b2_ovf",   out_overflow, 1);

        // Stall five cycles; sums and flushes offered meanwhile are ignored.
        for (int i = 0; i < 5; i++) begin
            put(1'b1, 99, (i == 2));
            tick();
            check("hold_valid",    out_valid,    1);
            check("hold_total",    out_total,    wrap_total);
            check("hold_count",    out_count,    4);
            check("hold_ovf",      out_overflow, 1);
            check("hold_in_ready", in_ready,     0);
        end
        put(1'b0, 0, 1'b0);
        out_ready = 1'b1;
        tick();
        check("b2_handoff_valid", out_valid, 0);
        check("b2_in_ready_back", in_ready,  1);

        // Partial batch 5,7 closed by flush; overflow must have been cleared.
        put(1'b1, 5, 1'b0); tick();
        put(1'b1, 7, 1'b0); tick();
        put(1'b0, 0, 1'b1); tick();
        put(1'b0, 0, 1'b0);
        check("fl1_valid", out_valid,    1);
        check("fl1_total", out_total,    12);
        check("fl1_count", out_count,    2);
        check("fl1_ovf",   out_overflow, 0);
        tick();
        check("fl1_handoff_valid", out_valid, 0);

        // Flush on an empty batch produces nothing.
        put(1'b0, 0, 1'b1); tick();
        put(1'b0, 0, 1'b0);
        check("fl_empty_valid",    out_valid, 0);
        check("fl_empty_in_ready", in_ready,  1);
        tick();
        check("fl_empty_valid2",   out_valid, 0);

        // Flush together with an accepted item includes that item.
        put(1'b1, 3, 1'b0); tick();
        put(1'b1, 9, 1'b1); tick();
        put(1'b0, 0, 1'b0);
        check("fl2_valid", out_valid, 1);
        check("fl2_total", out_total, 12);
        check("fl2_count", out_count, 2);
        tick();
        check("fl2_handoff_valid", out_valid, 0);

        // Asynchronous reset after two of four items.
        put(1'b1, 1, 1'b0); tick();
        put(1'b1, 1, 1'b0); tick();
        put(1'b0, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready",  in_ready,     0);
        check("arst_out_valid", out_valid,    0);
        check("arst_out_total", out_total,    0);
        check("arst_out_count", out_count,    0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("arst_in_ready_back", in_ready, 1);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put(1'b1, 1, 1'b0);
            tick();
        end
        put(1'b0, 0, 1'b0);
        check("post_rst_valid", out_valid, 1);
        check("post_rst_total", out_total, 4);
        check("post_rst_count", out_count, 4);

        // Reset while a result is held: it must vanish and never come back.
        #2;
        rst_n = 1'b0;
        #1;
        check("hold_rst_valid", out_valid, 0);
        check("hold_rst_total", out_total, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        check("hold_rst_in_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("discarded_stays_gone", out_valid, 0);
        end

        // A fresh single-item batch starts from an empty accumulator.
        put(1'b1, 6, 1'b1); tick();
        put(1'b0, 0, 1'b0);
        check("fresh_total", out_total, 6);
        check("fresh_count", out_count, 1);
        check("fresh_ovf",   out_overflow, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
